sb_init_ctrl: RTL
=================

// Module: sb_init_ctrl
// PURPOSE
//  Sequences the sideband SBINIT phase. Launches the SB clock-pattern generator, waits for its
//  pattern-done handshake, then runs the SBINIT "out of reset" message exchange with the link partner.
//  Enforces a global timeout on the whole sequence. Sits between the LTSM and the SB pattern
//  generator / SB message encoder-decoder.
// PARAMETERS
//  TIMEOUT_CYCLES  800000  cycles allowed from start to done (8 ms @ 100 MHz); min 16
//  MSG_W           8       width of sideband message code
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, localparam)
// PORTS
//  i_clk                  in   1      clock
//  i_rst_n                in   1      async active-low reset
//  i_sbinit_start         in   1      level from LTSM; rising edge starts sequence
//  i_abort                in   1      sync abort, any state -> IDLE
//  o_start_pattern_req    out  1      1-cycle pulse to pattern generator
//  i_start_pattern_done   in   1      pattern generator finished (partner pattern detected, tail sent)
//  i_pattern_time_out     in   1      pattern generator internal timeout
//  o_msg_req              out  1      1-cycle pulse: encoder sends o_msg_code
//  o_msg_code             out  MSG_W  code to send; valid with o_msg_req, held until next request
//  i_msg_sent             in   1      encoder finished sending last request
//  i_rx_msg_valid         in   1      decoder strobe
//  i_rx_msg_code          in   MSG_W  received code, valid with i_rx_msg_valid
//  o_sbinit_done          out  1      level: sequence complete
//  o_sbinit_timeout       out  1      level: sequence failed
// BEHAVIOUR
//  - Reset: all outputs 0, o_msg_code=0, state IDLE, counter 0, sticky flags 0. Async assert, sync release.
//  - States: IDLE, PATTERN, OOR_TX, OOR_WAIT, DONE, ERROR.
//  - IDLE: start edge (i_sbinit_start=1, registered copy=0) -> PATTERN. o_start_pattern_req=1
//    exactly in the cycle after the edge is sampled.
//  - PATTERN: i_start_pattern_done -> OOR_TX. i_pattern_time_out -> ERROR (timeout wins if both high).
//  - OOR_TX: one cycle. o_msg_req=1, o_msg_code=MSG_SBINIT_OOR. -> OOR_WAIT.
//  - OOR_WAIT: sticky flags: tx_ok on i_msg_sent; rx_ok on i_rx_msg_valid && code==MSG_SBINIT_OOR.
//    Other rx codes ignored. Flags may set in either order or the same cycle; a flag already set stays set.
//    Next cycle after both set -> DONE. An rx OOR arriving during PATTERN/OOR_TX is also captured
//    into rx_ok (partner may finish first).
//  - DONE: o_sbinit_done=1. Held until i_sbinit_start=0 -> IDLE, clearing flags and outputs.
//  - ERROR: o_sbinit_timeout=1. Held until i_sbinit_start=0 -> IDLE.
//  - Timeout counter: cleared in IDLE. Increments each cycle in PATTERN/OOR_TX/OOR_WAIT.
//    Reaching TIMEOUT_CYCLES-1 -> ERROR next cycle. Saturates, never wraps.
//    If done condition and timeout occur in the same cycle, done wins.
//  - i_abort: highest priority below reset. Any state -> IDLE next cycle, all outputs and flags cleared.
//    No pulse is emitted that cycle.
//  - i_sbinit_start held high after DONE/ERROR does not restart; a fresh rising edge is required.
//  - o_start_pattern_req and o_msg_req are never high together, and each is never high for 2 consecutive cycles.
// STRUCTURE
//  - Package sb_pkg: typedef enum logic [2:0] sb_init_state_e; localparam MSG_SBINIT_OOR=8'h91,
//    MSG_SBINIT_DONE_REQ=8'h95 (reserved for follow-on).
//  - Sub-module sb_timeout_cnt (clear/enable/expire, saturating), reused by later SB phases.
//  - One registered FSM; all outputs are registered.
// TESTING
//  1. Normal: start@t0, pattern_done at +20, msg_sent +3, rx OOR +10 -> done=1 at rx+2; one req pulse each.
//  2. Partner first: rx OOR during PATTERN, then pattern_done, msg_sent -> done 2 cycles after msg_sent.
//  3. Timeout: TIMEOUT_CYCLES=100, never pattern_done -> timeout=1 at cycle 101; done stays 0.
//  4. Pattern gen timeout: i_pattern_time_out at +5 -> ERROR next cycle; no o_msg_req ever.
//  5. Abort mid-OOR_WAIT, then reset mid-PATTERN -> outputs 0 and IDLE; new start edge reruns cleanly.
//  6. Start held high after DONE, wrong rx code (8'h00) in OOR_WAIT -> no restart; wrong code ignored.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared sideband types and message codes for the SB link-training phases.
package sb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PATTERN,
        ST_OOR_TX,
        ST_OOR_WAIT,
        ST_DONE,
        ST_ERROR
    } sb_init_state_e;

    localparam logic [7:0] MSG_SBINIT_OOR      = 8'h91;
    localparam logic [7:0] MSG_SBINIT_DONE_REQ = 8'h95;

endpackage

// File: rtl/sb_timeout_cnt.sv
// Saturating phase timeout counter: clear wins over enable, expire is a level once the
// count reaches TIMEOUT_CYCLES-1. Count updates one cycle after enable; no backpressure.
module sb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/sb_init_ctrl.sv
// SBINIT sequencer: pattern generator launch, then OOR message exchange, under a global timeout.
// All outputs registered (one cycle after the deciding input); no backpressure, pulses are one cycle.
module sb_init_ctrl
    import sb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int MSG_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sbinit_start,
    input  logic             i_abort,
    output logic             o_start_pattern_req,
    input  logic             i_start_pattern_done,
    input  logic             i_pattern_time_out,
    output logic             o_msg_req,
    output logic [MSG_W-1:0] o_msg_code,
    input  logic             i_msg_sent,
    input  logic             i_rx_msg_valid,
    input  logic [MSG_W-1:0] i_rx_msg_code,
    output logic             o_sbinit_done,
    output logic             o_sbinit_timeout
);

    localparam logic [MSG_W-1:0] OOR_CODE = MSG_W'(MSG_SBINIT_OOR);

    sb_init_state_e   r_state, w_next_state;
    logic             r_start_q;
    logic             r_spr, w_spr;
    logic             r_mreq, w_mreq;
    logic [MSG_W-1:0] r_code, w_code;
    logic             r_done, w_done;
    logic             r_to, w_to;
    logic             r_tx_ok, w_tx_ok;
    logic             r_rx_ok, w_rx_ok;
    logic             w_expire;
    logic             w_rx_hit;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    assign w_rx_hit  = i_rx_msg_valid && (i_rx_msg_code == OOR_CODE);
    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_cnt_en  = (r_state == ST_PATTERN) || (r_state == ST_OOR_TX) ||
                       (r_state == ST_OOR_WAIT);

    sb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next_state = r_state;
        w_spr        = 1'b0;
        w_mreq       = 1'b0;
        w_code       = r_code;
        w_done       = r_done;
        w_to         = r_to;
        w_tx_ok      = r_tx_ok;
        w_rx_ok      = r_rx_ok;

        if (i_abort) begin
            w_next_state = ST_IDLE;
            w_code       = '0;
            w_done       = 1'b0;
            w_to         = 1'b0;
            w_tx_ok      = 1'b0;
            w_rx_ok      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sbinit_start && !r_start_q) begin
                        w_next_state = ST_PATTERN;
                        w_spr        = 1'b1;
                    end
                end
                ST_PATTERN: begin
                    // Partner may finish its pattern first and send OOR early.
                    if (w_rx_hit) w_rx_ok = 1'b1;
                    if (i_pattern_time_out || w_expire) begin
                        w_next_state = ST_ERROR;
                        w_to         = 1'b1;
                    end else if (i_start_pattern_done) begin
                        w_next_state = ST_OOR_TX;
                        w_mreq       = 1'b1;
                        w_code       = OOR_CODE;
                    end
                end
                ST_OOR_TX: begin
                    if (w_rx_hit) w_rx_ok = 1'b1;
                    if (w_expire) begin
                        w_next_state = ST_ERROR;
                        w_to         = 1'b1;
                    end else begin
                        w_next_state = ST_OOR_WAIT;
                    end
                end
                ST_OOR_WAIT: begin
                    if (w_rx_hit)   w_rx_ok = 1'b1;
                    if (i_msg_sent) w_tx_ok = 1'b1;
                    if (r_tx_ok && r_rx_ok) begin
                        w_next_state = ST_DONE;
                        w_done       = 1'b1;
                    end else if (w_expire) begin
                        w_next_state = ST_ERROR;
                        w_to         = 1'b1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (!i_sbinit_start) begin
                        w_next_state = ST_IDLE;
                        w_code       = '0;
                        w_done       = 1'b0;
                        w_to         = 1'b0;
                        w_tx_ok      = 1'b0;
                        w_rx_ok      = 1'b0;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_spr     <= 1'b0;
            r_mreq    <= 1'b0;
            r_code    <= '0;
            r_done    <= 1'b0;
            r_to      <= 1'b0;
            r_tx_ok   <= 1'b0;
            r_rx_ok   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= i_sbinit_start;
            r_spr     <= w_spr;
            r_mreq    <= w_mreq;
            r_code    <= w_code;
            r_done    <= w_done;
            r_to      <= w_to;
            r_tx_ok   <= w_tx_ok;
            r_rx_ok   <= w_rx_ok;
        end
    end

    assign o_start_pattern_req = r_spr;
    assign o_msg_req           = r_mreq;
    assign o_msg_code          = r_code;
    assign o_sbinit_done       = r_done;
    assign o_sbinit_timeout    = r_to;

endmodule
